// File: rtl/axi_pkg.sv
// AXI3 slave memory: shared burst/response encodings, FSM states
// and burst legality helpers.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // WRAP is only legal for 2, 4, 8 or 16 beats (len+1 a power of 2).
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len != 4'd0) && ((len & (len + 4'd1)) == 4'd0);
  endfunction

  function automatic logic burst_err(
    input logic [3:0] len,
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [2:0] max_size
  );
    logic bad;
    bad = (size > max_size);
    case (burst_t'(burst))
      BURST_RSVD: bad = 1'b1;
      BURST_WRAP: if (!wrap_len_ok(len)) bad = 1'b1;
      default:    ;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/axi_slave_mem_addr_gen.sv
// AXI burst next-beat address generator (combinational).
// Ports: i_addr/i_len/i_size/i_burst current beat; o_next next beat address.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_len,
  input  logic [2:0]    i_size,
  input  logic [1:0]    i_burst,
  output logic [AW-1:0] o_next
);

  logic [AW-1:0] w_bytes;
  logic [AW-1:0] w_align;
  logic [AW-1:0] w_incr;
  logic [AW-1:0] w_total;
  logic [AW-1:0] w_bound;
  logic          w_wrap;
  logic          w_fixed;

  always_comb begin
    w_bytes = AW'(1) << i_size;
    w_align = i_addr & ~(w_bytes - AW'(1));
    w_incr  = w_align + w_bytes;
    w_total = AW'({1'b0, i_len} + 5'd1) << i_size;
    w_bound = i_addr & ~(w_total - AW'(1));
    w_fixed = (burst_t'(i_burst) == BURST_FIXED);
    // Illegal WRAP lengths and reserved encodings fall back to INCR.
    w_wrap  = (burst_t'(i_burst) == BURST_WRAP) && wrap_len_ok(i_len);
    o_next  = w_incr;
    if (w_fixed) begin
      o_next = i_addr;
    end else if (w_wrap && (w_incr == w_bound + w_total)) begin
      o_next = w_bound;
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 slave backed by a word-addressed RAM; independent write/read FSMs,
// one outstanding burst per path. Ports: AW/W/B and AR/R AXI3 channels.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int AXI_ADRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8,
  parameter int AID_WIDTH        = 4,
  parameter int MEM_DEPTH        = 1024
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [AID_WIDTH-1:0]        AWID,
  input  logic [AXI_ADRESS_WIDTH-1:0] AWADDR,
  input  logic [3:0]                  AWLEN,
  input  logic [2:0]                  AWSIZE,
  input  logic [1:0]                  AWBURST,
  input  logic [1:0]                  AWLOCK,
  input  logic [3:0]                  AWCACHE,
  input  logic [2:0]                  AWPROT,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AID_WIDTH-1:0]        WID,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_STRB_WIDTH-1:0]   WSTRB,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [AID_WIDTH-1:0]        BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [AID_WIDTH-1:0]        ARID,
  input  logic [AXI_ADRESS_WIDTH-1:0] ARADDR,
  input  logic [3:0]                  ARLEN,
  input  logic [2:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic [1:0]                  ARLOCK,
  input  logic [3:0]                  ARCACHE,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [AID_WIDTH-1:0]        RID,
  output logic [AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY
);

  localparam int AW    = AXI_ADRESS_WIDTH;
  localparam int DW    = AXI_DATA_WIDTH;
  localparam int SW    = AXI_STRB_WIDTH;
  localparam int SHIFT = $clog2(SW);
  localparam int IW    = $clog2(MEM_DEPTH);
  localparam logic [2:0]    MAX_SIZE = 3'(SHIFT);
  localparam logic [AW-1:0] DEPTH_A  = AW'(MEM_DEPTH);

  logic [DW-1:0] r_mem [MEM_DEPTH];

  // LOCK/CACHE/PROT carry no meaning for this memory.
  logic w_unused;
  assign w_unused = ^{AWLOCK, AWCACHE, AWPROT,
                      ARLOCK, ARCACHE, ARPROT};

  // ---------------- write path ----------------
  wstate_t              r_wstate;
  logic [AID_WIDTH-1:0] r_awid;
  logic [AW-1:0]        r_waddr;
  logic [3:0]           r_awlen;
  logic [3:0]           r_wbeat;
  logic [2:0]           r_awsize;
  logic [1:0]           r_awburst;
  logic                 r_werr;

  logic [AW-1:0] w_wnext;
  logic [AW-1:0] w_widx;
  logic          w_wfire;
  logic          w_wlast_beat;
  logic          w_wbad;
  logic          w_we;

  axi_burst_addr_gen #(.AW(AW)) u_wgen (
    .i_addr  (r_waddr),
    .i_len   (r_awlen),
    .i_size  (r_awsize),
    .i_burst (r_awburst),
    .o_next  (w_wnext)
  );

  assign w_widx       = r_waddr >> SHIFT;
  assign w_wfire      = (r_wstate == W_DATA) && WVALID && WREADY;
  assign w_wlast_beat = (r_wbeat == r_awlen);
  // A beat that fails its own checks is not committed to RAM.
  assign w_wbad = (WID != r_awid)
               || (WLAST != w_wlast_beat)
               || (w_widx >= DEPTH_A);
  assign w_we   = w_wfire && !w_wbad;

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int i = 0; i < SW; i++) begin
        if (WSTRB[i]) begin
          r_mem[w_widx[IW-1:0]][i*8 +: 8] <= WDATA[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      AWREADY   <= 1'b1;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BID       <= '0;
      BRESP     <= '0;
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            r_awid    <= AWID;
            r_waddr   <= AWADDR;
            r_awlen   <= AWLEN;
            r_awsize  <= AWSIZE;
            r_awburst <= AWBURST;
            r_wbeat   <= '0;
            r_werr    <= burst_err(AWLEN, AWSIZE,
                                   AWBURST, MAX_SIZE);
            AWREADY   <= 1'b0;
            WREADY    <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wfire) begin
            r_waddr <= w_wnext;
            r_wbeat <= r_wbeat + 4'd1;
            if (w_wbad) r_werr <= 1'b1;
            // Burst length comes from AWLEN, not from WLAST.
            if (w_wlast_beat) begin
              WREADY   <= 1'b0;
              BVALID   <= 1'b1;
              BID      <= r_awid;
              BRESP    <= (r_werr || w_wbad) ? RESP_SLVERR
                                             : RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BVALID && BREADY) begin
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rstate_t       r_rstate;
  logic [AW-1:0] r_raddr;
  logic [3:0]    r_arlen;
  logic [3:0]    r_rbeat;
  logic [2:0]    r_arsize;
  logic [1:0]    r_arburst;
  logic          r_rerr;

  logic [AW-1:0] w_rnext;
  logic [AW-1:0] w_ar_idx;
  logic [AW-1:0] w_rn_idx;
  logic          w_ar_err;

  axi_burst_addr_gen #(.AW(AW)) u_rgen (
    .i_addr  (r_raddr),
    .i_len   (r_arlen),
    .i_size  (r_arsize),
    .i_burst (r_arburst),
    .o_next  (w_rnext)
  );

  assign w_ar_idx = ARADDR >> SHIFT;
  assign w_rn_idx = w_rnext >> SHIFT;
  assign w_ar_err = burst_err(ARLEN, ARSIZE, ARBURST, MAX_SIZE);

  // RDATA loads sample r_mem before this edge's write lands,
  // so a same-cycle collision returns the old word.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      ARREADY   <= 1'b1;
      RVALID    <= 1'b0;
      RLAST     <= 1'b0;
      RID       <= '0;
      RRESP     <= '0;
      RDATA     <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rbeat   <= '0;
      r_rerr    <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            r_raddr   <= ARADDR;
            r_arlen   <= ARLEN;
            r_arsize  <= ARSIZE;
            r_arburst <= ARBURST;
            r_rbeat   <= '0;
            r_rerr    <= w_ar_err;
            RID       <= ARID;
            RLAST     <= (ARLEN == 4'd0);
            RVALID    <= 1'b1;
            ARREADY   <= 1'b0;
            if (w_ar_idx < DEPTH_A) begin
              RDATA <= r_mem[w_ar_idx[IW-1:0]];
              RRESP <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
              RDATA <= '0;
              RRESP <= RESP_SLVERR;
            end
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (RVALID && RREADY) begin
            if (RLAST) begin
              RVALID   <= 1'b0;
              ARREADY  <= 1'b1;
              r_rstate <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rbeat <= r_rbeat + 4'd1;
              RLAST   <= ((r_rbeat + 4'd1) == r_arlen);
              if (w_rn_idx < DEPTH_A) begin
                RDATA <= r_mem[w_rn_idx[IW-1:0]];
                RRESP <= r_rerr ? RESP_SLVERR : RESP_OKAY;
              end else begin
                RDATA <= '0;
                RRESP <= RESP_SLVERR;
              end
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem.
// Drives AXI3 bursts and compares against hand-computed values.
module tb_axi_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [1:0]  AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_slave_mem u_dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK),
    .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  ri [16];
  int          nbeats;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr,
                    input logic [3:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [3:0] strb,
                    input logic [3:0] wid, input int last_at,
                    input int bdly,
                    output logic [1:0] resp, output logic [3:0] bid);
    int k;
    AWID = id; AWADDR = addr; AWLEN = len;
    AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    k = 0;
    while (!AWREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    if (!AWREADY) chk("aw_timeout", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WID = wid; WDATA = wd[b]; WSTRB = strb;
      WLAST = (b == last_at); WVALID = 1'b1;
      k = 0;
      while (!WREADY && k < 50) begin @(posedge ACLK); #1; k++; end
      if (!WREADY) chk("w_timeout", WREADY, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    k = 0;
    while (!BVALID && k < 50) begin @(posedge ACLK); #1; k++; end
    if (!BVALID) chk("b_timeout", BVALID, 1);
    resp = BRESP; bid = BID;
    for (int d = 0; d < bdly; d++) begin
      @(posedge ACLK); #1;
      chk("b_hold", {BVALID, BID, BRESP}, {1'b1, bid, resp});
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic rdb(input logic [3:0] id, input logic [31:0] addr,
                     input logic [3:0] len, input logic [1:0] burst,
                     input bit tog);
    int k;
    bit stalled;
    logic [39:0] snap;
    ARID = id; ARADDR = addr; ARLEN = len;
    ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    k = 0;
    while (!ARREADY && k < 50) begin @(posedge ACLK); #1; k++; end
    if (!ARREADY) chk("ar_timeout", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    nbeats = 0; k = 0; stalled = 1'b0; snap = '0;
    while (nbeats <= int'(len) && k < 100) begin
      if (stalled)
        chk("r_hold", {RVALID, RID, RRESP, RLAST, RDATA}, snap);
      RREADY = tog ? k[0] : 1'b1;
      stalled = 1'b0;
      if (RVALID && RREADY) begin
        rd[nbeats] = RDATA; rr[nbeats] = RRESP;
        rl[nbeats] = RLAST; ri[nbeats] = RID;
        nbeats++;
      end else if (RVALID) begin
        stalled = 1'b1;
        snap = {RVALID, RID, RRESP, RLAST, RDATA};
      end
      @(posedge ACLK); #1;
      k++;
    end
    RREADY = 1'b0;
    chk("r_beats", nbeats, int'(len) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic [3:0] bid;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    AWLOCK = 0; AWCACHE = 0; AWPROT = 0; AWVALID = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0;
    BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0;
    ARLOCK = 0; ARCACHE = 0; ARPROT = 0; ARVALID = 0;
    RREADY = 0;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    chk("rst_awready", AWREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_bid_bresp", {BID, BRESP}, 0);
    chk("rst_rdata", {RID, RRESP, RDATA}, 0);

    // INCR write then read back
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    wr(4'h5, 32'h10, 4'd3, 3'd2, 2'b01, 4'hF, 4'h5, 3, 0, resp, bid);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", bid, 4'h5);
    rdb(4'h3, 32'h10, 4'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rd[i], 32'hA0 + i);
      chk("incr_rlast", rl[i], (i == 3));
      chk("incr_rresp", rr[i], 2'b00);
      chk("incr_rid", ri[i], 4'h3);
    end
    chk("rdone_rvalid", RVALID, 0);
    chk("rdone_arready", ARREADY, 1);

    // WRAP read: 0x38,0x3C,0x30,0x34
    for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + i;
    wr(4'h1, 32'h30, 4'd3, 3'd2, 2'b01, 4'hF, 4'h1, 3, 0, resp, bid);
    chk("wrapfill_bresp", resp, 2'b00);
    rdb(4'h2, 32'h38, 4'd3, 2'b10, 1'b0);
    chk("wrap_b0", rd[0], 32'hB2);
    chk("wrap_b1", rd[1], 32'hB3);
    chk("wrap_b2", rd[2], 32'hB0);
    chk("wrap_b3", rd[3], 32'hB1);
    chk("wrap_rresp", {rr[0], rr[1], rr[2], rr[3]}, 8'h00);

    // Reserved burst: INCR addressing, SLVERR per beat
    rdb(4'h4, 32'h10, 4'd1, 2'b11, 1'b0);
    chk("rsvd_d0", rd[0], 32'hA0);
    chk("rsvd_d1", rd[1], 32'hA1);
    chk("rsvd_rresp", {rr[0], rr[1]}, 4'b1010);

    // Partial strobe
    wd[0] = 32'h11223344;
    wr(4'h1, 32'h0, 4'd0, 3'd2, 2'b01, 4'hF, 4'h1, 0, 0, resp, bid);
    wd[0] = 32'hAABBCCDD;
    wr(4'h1, 32'h0, 4'd0, 3'd2, 2'b01, 4'b0101, 4'h1, 0, 0, resp, bid);
    chk("strb_bresp", resp, 2'b00);
    rdb(4'h1, 32'h0, 4'd0, 2'b01, 1'b0);
    chk("strb_rdata", rd[0], 32'h11BB33DD);
    chk("strb_rlast", rl[0], 1);

    // Early WLAST on beat 2 of 4: mismatched beats not written
    for (int i = 0; i < 4; i++) wd[i] = 32'hD0 + i;
    wr(4'h4, 32'h200, 4'd3, 3'd2, 2'b01, 4'hF, 4'h4, 3, 0, resp, bid);
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + i;
    wr(4'h4, 32'h200, 4'd3, 3'd2, 2'b01, 4'hF, 4'h4, 1, 0, resp, bid);
    chk("wlast_bresp", resp, 2'b10);
    chk("wlast_bid", bid, 4'h4);
    rdb(4'h4, 32'h200, 4'd3, 2'b01, 1'b0);
    chk("wlast_d0", rd[0], 32'hC0);
    chk("wlast_d1", rd[1], 32'hD1);
    chk("wlast_d2", rd[2], 32'hC2);
    chk("wlast_d3", rd[3], 32'hD3);

    // WID != AWID
    wd[0] = 32'h12345678;
    wr(4'h2, 32'h300, 4'd0, 3'd2, 2'b01, 4'hF, 4'h2, 0, 0, resp, bid);
    wd[0] = 32'hDEADBEEF;
    wr(4'h2, 32'h300, 4'd0, 3'd2, 2'b01, 4'hF, 4'h7, 0, 0, resp, bid);
    chk("wid_bresp", resp, 2'b10);
    chk("wid_bid", bid, 4'h2);
    rdb(4'h2, 32'h300, 4'd0, 2'b01, 1'b0);
    chk("wid_rdata", rd[0], 32'h12345678);

    // Out-of-range address (MEM_DEPTH*4)
    wd[0] = 32'hCAFEF00D;
    wr(4'h6, 32'h1000, 4'd0, 3'd2, 2'b01, 4'hF, 4'h6, 0, 0, resp, bid);
    chk("oor_bresp", resp, 2'b10);
    rdb(4'h6, 32'h1000, 4'd0, 2'b01, 1'b0);
    chk("oor_rresp", rr[0], 2'b10);
    chk("oor_rdata", rd[0], 32'h0);
    rdb(4'h6, 32'h0, 4'd0, 2'b01, 1'b0);
    chk("oor_no_alias", rd[0], 32'h11BB33DD);

    // Oversized SIZE
    wd[0] = 32'h5;
    wr(4'h8, 32'h700, 4'd0, 3'd3, 2'b01, 4'hF, 4'h8, 0, 0, resp, bid);
    chk("size_bresp", resp, 2'b10);

    // Backpressure: B held 5 cycles, RREADY toggling
    for (int i = 0; i < 4; i++) wd[i] = 32'hE0 + i;
    wr(4'h9, 32'h400, 4'd3, 3'd2, 2'b01, 4'hF, 4'h9, 3, 5, resp, bid);
    chk("bp_bresp", resp, 2'b00);
    chk("bp_bid", bid, 4'h9);
    rdb(4'h9, 32'h400, 4'd3, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_rdata", rd[i], 32'hE0 + i);
      chk("bp_rlast", rl[i], (i == 3));
    end

    // Reset after 2 of 4 write beats
    AWID = 4'h1; AWADDR = 32'h500; AWLEN = 4'd3;
    AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WID = 4'h1; WDATA = 32'hF0 + b; WSTRB = 4'hF;
      WLAST = 1'b0; WVALID = 1'b1;
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk("mrst_awready", AWREADY, 1);
    chk("mrst_wready", WREADY, 0);
    chk("mrst_bvalid", BVALID, 0);
    wd[0] = 32'h600; wd[1] = 32'h601;
    wr(4'h3, 32'h600, 4'd1, 3'd2, 2'b01, 4'hF, 4'h3, 1, 0, resp, bid);
    chk("mrst_bresp", resp, 2'b00);
    rdb(4'h3, 32'h600, 4'd1, 2'b01, 1'b0);
    chk("mrst_new_d0", rd[0], 32'h600);
    chk("mrst_new_d1", rd[1], 32'h601);
    chk("mrst_new_rresp", {rr[0], rr[1]}, 4'b0000);
    rdb(4'h3, 32'h500, 4'd1, 2'b01, 1'b0);
    chk("mrst_old_d0", rd[0], 32'hF0);
    chk("mrst_old_d1", rd[1], 32'hF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
